// File: rtl/divider_u_pkg.sv
// Shared definitions for the unsigned sequential divider.
package divider_u_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Fill bit for the quotient reported on divide-by-zero or overflow.
    localparam logic ERR_QUOT_FILL = 1'b1;

endpackage

// File: rtl/divider_u_div_step.sv
// One restoring shift-subtract step: subtract the divisor from the shifted
// partial remainder if it fits, producing the next remainder and quotient bit.
module divider_u_div_step
    import divider_u_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic             in_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] next_rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   neg_div;
    logic [WIDTH+1:0] sum;
    logic             sum_unused;

    assign trial   = {rem_i, in_bit_i};
    assign neg_div = ~{1'b0, divisor_i};

    // Adder with carry-in of one computes trial - divisor; the carry-out is
    // set exactly when no borrow occurred, i.e. trial >= divisor.
    assign sum = {1'b0, trial} + {1'b0, neg_div} + {{(WIDTH + 1){1'b0}}, 1'b1};

    assign q_bit_o    = sum[WIDTH+1];
    // A successful subtraction always leaves a value below the divisor, so
    // the low WIDTH bits hold the whole result.
    assign next_rem_o = q_bit_o ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
    assign sum_unused = sum[WIDTH];

endmodule

// File: rtl/divider_u.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; results and flags held
// RUN   | iterating, one quotient bit per clock
module divider_u
    import divider_u_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] DIVIDEND_HIGH,
    input  logic [WIDTH-1:0] DIVIDEND_LOW,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             is_zero;
    logic             is_ovf;
    logic             last_iter;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign accept    = start && (state_q == IDLE);
    assign is_zero   = (DIVISOR == '0);
    // A high half at or above the divisor means the quotient needs more
    // than WIDTH bits; rejecting it also bounds the partial remainder.
    assign is_ovf    = !is_zero && (DIVIDEND_HIGH >= DIVISOR);
    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(1));

    divider_u_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .in_bit_i   (q_q[WIDTH-1]),
        .divisor_i  (dvs_q),
        .next_rem_o (step_rem),
        .q_bit_o    (step_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: only a valid (non-error) request enters RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !is_zero && !is_ovf) state_d = RUN;
            RUN:     if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Datapath next values: operand capture, iteration and result load.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        if (accept) begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            dvs_d = DIVISOR;
            if (is_zero || is_ovf) begin
                dbz_d  = is_zero;
                ovf_d  = is_ovf;
                quot_d = {WIDTH{ERR_QUOT_FILL}};
                remo_d = DIVIDEND_LOW;
                done_d = 1'b1;
            end else begin
                rem_d = DIVIDEND_HIGH;
                q_d   = DIVIDEND_LOW;
                cnt_d = CNT_W'(WIDTH);
            end
        end else if (state_q == RUN) begin
            rem_d = step_rem;
            q_d   = {q_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - CNT_W'(1);
            if (last_iter) begin
                quot_d = {q_q[WIDTH-2:0], step_q};
                remo_d = step_rem;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            remo_q <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            q_q    <= q_d;
            dvs_q  <= dvs_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign QUOTIENT    = quot_q;
    assign REMAINDER   = remo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_u.sv
// Directed self-checking bench for divider_u.
module tb_divider_u;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] DIVIDEND_HIGH;
    logic [31:0] DIVIDEND_LOW;
    logic [31:0] DIVISOR;
    logic [31:0] QUOTIENT;
    logic [31:0] REMAINDER;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    divider_u dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .DIVIDEND_HIGH (DIVIDEND_HIGH),
        .DIVIDEND_LOW  (DIVIDEND_LOW),
        .DIVISOR       (DIVISOR),
        .QUOTIENT      (QUOTIENT),
        .REMAINDER     (REMAINDER),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a request for one cycle; returns at the negedge of cycle T.
    task automatic issue(input logic [31:0] h, input logic [31:0] l, input logic [31:0] d);
        @(negedge clk);
        DIVIDEND_HIGH = h;
        DIVIDEND_LOW  = l;
        DIVISOR       = d;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advance one cycle at a time until done, bounded; reports cycles waited
    // and whether busy was ever low before done appeared.
    task automatic wait_done(output int n, output bit busy_gap);
        n = 0;
        busy_gap = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        DIVIDEND_HIGH = '0;
        DIVIDEND_LOW = '0;
        DIVISOR = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (QUOTIENT !== 32'd0) $display("FAIL reset_q got %h want 0", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd0) $display("FAIL reset_r got %h want 0", REMAINDER); else pass_cnt++;
        total_cnt++; if ({busy, done, div_by_zero, overflow} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {busy, done, div_by_zero, overflow}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_simple;
        int n; bit gap;
        issue(32'd0, 32'd100, 32'd7);
        total_cnt++; if (busy !== 1'b1) $display("FAIL simple_busy_T got %b want 1", busy); else pass_cnt++;
        wait_done(n, gap);
        total_cnt++; if (n !== 32) $display("FAIL simple_latency got %0d want 32", n); else pass_cnt++;
        total_cnt++; if (gap !== 1'b0) $display("FAIL simple_busy_gap got %b want 0", gap); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL simple_busy_done got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'd14) $display("FAIL simple_q got %h want %h", QUOTIENT, 32'd14); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd2) $display("FAIL simple_r got %h want %h", REMAINDER, 32'd2); else pass_cnt++;
        total_cnt++; if ({div_by_zero, overflow} !== 2'b00) $display("FAIL simple_flags got %b want 00", {div_by_zero, overflow}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL simple_done_pulse got %b want 0", done); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'd14) $display("FAIL simple_q_hold got %h want %h", QUOTIENT, 32'd14); else pass_cnt++;
    endtask

    task automatic test_round_trip;
        int n; bit gap;
        issue(32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF);
        wait_done(n, gap);
        total_cnt++; if (n !== 32) $display("FAIL rt_latency got %0d want 32", n); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'hFFFF_FFFF) $display("FAIL rt_q got %h want ffffffff", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd0) $display("FAIL rt_r got %h want 0", REMAINDER); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL rt_ovf got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_pow2;
        int n; bit gap;
        issue(32'h0000_0001, 32'h0000_0000, 32'd2);
        wait_done(n, gap);
        total_cnt++; if (QUOTIENT !== 32'h8000_0000) $display("FAIL pow2_q got %h want 80000000", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd0) $display("FAIL pow2_r got %h want 0", REMAINDER); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        issue(32'd7, 32'h0000_1234, 32'd0);
        total_cnt++; if (done !== 1'b1) $display("FAIL dbz_done got %b want 1", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL dbz_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({div_by_zero, overflow} !== 2'b10) $display("FAIL dbz_flags got %b want 10", {div_by_zero, overflow}); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'hFFFF_FFFF) $display("FAIL dbz_q got %h want ffffffff", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'h0000_1234) $display("FAIL dbz_r got %h want 00001234", REMAINDER); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({done, busy, div_by_zero} !== 3'b001) $display("FAIL dbz_after got %b want 001", {done, busy, div_by_zero}); else pass_cnt++;
    endtask

    task automatic test_overflow;
        issue(32'd5, 32'd9, 32'd5);
        total_cnt++; if ({done, busy} !== 2'b10) $display("FAIL ovf_done_busy got %b want 10", {done, busy}); else pass_cnt++;
        total_cnt++; if ({div_by_zero, overflow} !== 2'b01) $display("FAIL ovf_flags got %b want 01", {div_by_zero, overflow}); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'hFFFF_FFFF) $display("FAIL ovf_q got %h want ffffffff", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd9) $display("FAIL ovf_r got %h want 9", REMAINDER); else pass_cnt++;
    endtask

    task automatic test_busy_ignore;
        int n; bit gap;
        issue(32'd0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        DIVIDEND_LOW = 32'd50;
        DIVISOR = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, gap);
        total_cnt++; if (n + 10 !== 32) $display("FAIL ign_latency got %0d want 32", n + 10); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'd14) $display("FAIL ign_q got %h want %h", QUOTIENT, 32'd14); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd2) $display("FAIL ign_r got %h want %h", REMAINDER, 32'd2); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({done, busy} !== 2'b00) $display("FAIL ign_not_queued got %b want 00", {done, busy}); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int n; bit gap; bit saw_done;
        issue(32'd0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({busy, done, div_by_zero, overflow} !== 4'b0000)
            $display("FAIL rstmid_flags got %b want 0000", {busy, done, div_by_zero, overflow}); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'd0) $display("FAIL rstmid_q got %h want 0", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd0) $display("FAIL rstmid_r got %h want 0", REMAINDER); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", saw_done); else pass_cnt++;
        issue(32'd0, 32'd9, 32'd3);
        wait_done(n, gap);
        total_cnt++; if (QUOTIENT !== 32'd3) $display("FAIL rstmid_new_q got %h want 3", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'd0) $display("FAIL rstmid_new_r got %h want 0", REMAINDER); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n; bit gap;
        issue(32'd0, 32'd100, 32'd7);
        wait_done(n, gap);
        DIVIDEND_HIGH = 32'd0;
        DIVIDEND_LOW = 32'hDEAD_BEEF;
        DIVISOR = 32'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if ({done, busy} !== 2'b01) $display("FAIL b2b_accept got %b want 01", {done, busy}); else pass_cnt++;
        wait_done(n, gap);
        total_cnt++; if (n !== 32) $display("FAIL b2b_latency got %0d want 32", n); else pass_cnt++;
        total_cnt++; if (QUOTIENT !== 32'h0DEA_DBEE) $display("FAIL b2b_q got %h want 0deadbee", QUOTIENT); else pass_cnt++;
        total_cnt++; if (REMAINDER !== 32'hF) $display("FAIL b2b_r got %h want f", REMAINDER); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_simple();
        test_round_trip();
        test_pow2();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
